// File: rtl/uart_pkg.sv
// uart_pkg: shared UART byte type and default receive-queue sizing.
package uart_pkg;
    localparam int UART_BYTE_W         = 8;
    localparam int UART_RX_QUEUE_DEPTH = 16;
    localparam int UART_RX_QUEUE_AFULL = 12;
    typedef logic [UART_BYTE_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_rx_queue_mem.sv
// uart_rx_queue_mem: DEPTH x byte register array, one write port, one asynchronous read port.
module uart_rx_queue_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_QUEUE_DEPTH
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  uart_byte_t               wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output uart_byte_t               rd_data
);
    uart_byte_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/uart_rx_queue.sv
// uart_rx_queue: circular byte FIFO behind uart_top with occupancy and sticky overflow status.
// Define UART_RX_QUEUE_FWFT_EN for first-word fall-through reads.
module uart_rx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH       = UART_RX_QUEUE_DEPTH,
    parameter int AFULL_LEVEL = UART_RX_QUEUE_AFULL
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  uart_byte_t               rx_data,
    input  logic                     rx_done,
    input  logic                     rd_en,
    output uart_byte_t               rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     overflow,
    input  logic                     ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          rx_done_q, rx_done_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d, full_q, full_d, afull_q, afull_d, ovf_q, ovf_d;
    logic          rd_valid_q, rd_valid_d;
    uart_byte_t    rd_data_q, rd_data_d, head;
    logic          wr_stb, rd_acc, wr_acc;

    uart_rx_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk    (clk),
        .wr_en  (wr_acc),
        .wr_addr(wr_ptr_q),
        .wr_data(rx_data),
        .rd_addr(rd_ptr_q),
        .rd_data(head)
    );

    always_comb begin
        rx_done_d  = rx_done;
        wr_stb     = rx_done & ~rx_done_q;
        rd_acc     = rd_en & ~empty_q;
        wr_acc     = wr_stb & (~full_q | rd_acc);
        wr_ptr_d   = wr_ptr_q + AW'(wr_acc);
        rd_ptr_d   = rd_ptr_q + AW'(rd_acc);
        count_d    = count_q + CW'(wr_acc) - CW'(rd_acc);
        empty_d    = count_d == '0;
        full_d     = count_d == CW'(DEPTH);
        afull_d    = count_d >= CW'(AFULL_LEVEL);
        ovf_d      = (wr_stb & ~wr_acc) | (ovf_q & ~ovf_clr);
        // Standard mode: the popped byte. FWFT mode: value held once the queue drains.
        rd_data_d  = rd_acc ? head : rd_data_q;
`ifdef UART_RX_QUEUE_FWFT_EN
        rd_valid_d = ~empty_d;
`else
        rd_valid_d = rd_acc;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_done_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            ovf_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rx_done_q  <= rx_done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef UART_RX_QUEUE_FWFT_EN
    assign rd_data = empty_q ? rd_data_q : head;
`else
    assign rd_data = rd_data_q;
`endif
    assign rd_valid    = rd_valid_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign count       = count_q;
    assign almost_full = afull_q;
    assign overflow    = ovf_q;
endmodule
